// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller.
// Holds func3 codes, FSM states, the latched request and byte_en().
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [3:0] byte_en(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << off;
      F3_H, F3_HU: be = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data memory.
// master = pipeline side, slave = dmem_ctrl side.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_func3,
    output req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_func3,
    input  req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store replication + byte enables,
// load lane select/extension and error decode (func3/align/range).
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam logic [31:0] DW = 32'(DEPTH_WORDS);

  logic [1:0]  w_off;
  logic        w_f3_ok;
  logic        w_mis;
  logic        w_oor;
  logic [31:0] w_sh;

  assign w_off = i_addr[1:0];
  assign w_oor = {2'b00, i_addr[31:2]} >= DW;
  assign w_sh  = i_rword >> {w_off, 3'b000};

  always_comb begin
    w_f3_ok = 1'b0;
    w_mis   = 1'b0;
    unique case (1'b1)
      (i_func3 == F3_B): w_f3_ok = 1'b1;
      (i_func3 == F3_H): begin
        w_f3_ok = 1'b1;
        w_mis   = w_off[0];
      end
      (i_func3 == F3_W): begin
        w_f3_ok = 1'b1;
        w_mis   = (w_off != 2'b00);
      end
      (i_func3 == F3_BU): w_f3_ok = !i_we;
      (i_func3 == F3_HU): begin
        w_f3_ok = !i_we;
        w_mis   = w_off[0];
      end
      default: w_f3_ok = 1'b0;
    endcase
  end

  assign o_err = !w_f3_ok || w_mis || w_oor;

  assign o_be = (i_we && !o_err) ?
                byte_en(i_func3, w_off) : 4'b0000;

  always_comb begin
    o_wdata = i_wdata;
    case (i_func3)
      F3_B:    o_wdata = {4{i_wdata[7:0]}};
      F3_H:    o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  always_comb begin
    o_rdata = 32'h0;
    if (!i_we && !o_err) begin
      case (i_func3)
        F3_B:  o_rdata = {{24{w_sh[7]}}, w_sh[7:0]};
        F3_H:  o_rdata = {{16{w_sh[15]}}, w_sh[15:0]};
        F3_W:  o_rdata = i_rword;
        F3_BU: o_rdata = {24'h0, w_sh[7:0]};
        F3_HU: o_rdata = {16'h0, w_sh[15:0]};
        default: o_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: IDLE/WAIT/RESP FSM, wait
// counter, byte-enabled storage. Ports: clk, rst, bus (slave).
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAST =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      r_state;
  state_t      w_next;
  req_t        r_req;
  req_t        w_live;
  req_t        w_cur;
  logic [3:0]  r_cnt;
  logic        w_ready;
  logic        w_accept;
  logic        w_enter;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wrep;
  logic [31:0]   w_rext;
  logic          w_err;

  assign w_live = '{
    we:    bus.req_we,
    func3: bus.req_func3,
    addr:  bus.req_addr,
    wdata: bus.req_wdata
  };

  // With no wait states the access happens on the accept
  // edge itself, so the lanes must see the live request.
  assign w_cur    = (r_state == S_IDLE) ? w_live : r_req;
  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_idx    = w_cur.addr[AW+1:2];
  assign w_rword  = r_mem[w_idx];

  dmem_lane_align #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_lane (
    .i_we    (w_cur.we),
    .i_func3 (w_cur.func3),
    .i_addr  (w_cur.addr),
    .i_wdata (w_cur.wdata),
    .i_rword (w_rword),
    .o_be    (w_be),
    .o_wdata (w_wrep),
    .o_rdata (w_rext),
    .o_err   (w_err)
  );

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_enter = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (WAIT_STATES == 0) begin
            w_next  = S_RESP;
            w_enter = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == LAST) begin
          w_next  = S_RESP;
          w_enter = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || r_state != S_WAIT) r_cnt <= 4'd0;
    else                          r_cnt <= r_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)           r_req <= '0;
    else if (w_accept) r_req <= w_live;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= w_enter;
      if (w_enter) begin
        r_resp_rdata <= w_rext;
        r_resp_err   <= w_err;
      end
    end
  end

  // w_be is already zero for loads and errors.
  always_ff @(posedge clk) begin
    if (w_enter && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
